// File: rtl/tight_matmul_pkg.sv
// Shared opcodes, FSM state type and response error flags for the
// tightly-coupled matrix-multiply accelerator.
package tight_matmul_pkg;

  localparam logic [5:0] OP_MULT  = 6'd1;
  localparam logic [5:0] OP_FILLA = 6'd2;
  localparam logic [5:0] OP_FILLB = 6'd3;
  localparam logic [5:0] OP_READ  = 6'd4;
  localparam logic [5:0] OP_CLEAR = 6'd5;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESP
  } state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/tight_matmul_acc_mac.sv
// Combinational multiply-accumulate: acc_n = (clr ? 0 : acc) + a*b, modulo 2^ACC_W.
// Operands are treated as signed or unsigned according to SIGNED.
module tight_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc_n
);

  // One guard bit keeps the full unsigned product representable as a signed value.
  localparam int PW = 2 * DATA_W + 1;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic        [ACC_W-1:0] base;

  always_comb begin
    a_ext = (SIGNED != 0) ? PW'($signed(a)) : PW'($signed({1'b0, a}));
    b_ext = (SIGNED != 0) ? PW'($signed(b)) : PW'($signed({1'b0, b}));
    prod  = a_ext * b_ext;
    base  = clr ? '0 : acc;
    acc_n = base + ACC_W'(prod);
  end

endmodule

// File: rtl/tight_matmul_acc.sv
// DIMxDIM matrix-multiply accelerator on a command/response port: loads A and B
// element by element, runs one MAC per cycle for DIM^3 cycles, returns C element by element.
module tight_matmul_acc
  import tight_matmul_pkg::*;
#(
  parameter int DIM    = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_val,
  output logic        busy,
  input  logic [5:0]  cmd_opcode,
  input  logic [63:0] cmd_config_data,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int NE = DIM * DIM;
  localparam int PW = $clog2(NE);
  localparam int IW = $clog2(DIM);
  localparam logic [PW-1:0] LAST_P = PW'(NE - 1);
  localparam logic [IW-1:0] LAST_I = IW'(DIM - 1);
  localparam logic [63:0]   CYCLES = 64'(DIM * DIM * DIM);

  state_t state;

  logic [PW-1:0] a_ptr, b_ptr, rd_ptr;
  logic          a_full, b_full, c_valid;
  logic [IW-1:0] ci, cj, ck;

  logic [DATA_W-1:0] a_mem [NE];
  logic [DATA_W-1:0] b_mem [NE];
  logic [ACC_W-1:0]  c_mem [NE];
  logic [ACC_W-1:0]  acc, acc_n;

  logic [PW-1:0] a_idx, b_idx, c_idx;
  logic          accept, last_k, last_mac;
  logic          unused_bits;

  function automatic logic [63:0] ext64(input logic [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sv;
    sv = v;
    if (SIGNED != 0) return 64'(sv);
    return 64'(v);
  endfunction

  function automatic logic [PW-1:0] flat(input logic [IW-1:0] row, input logic [IW-1:0] col);
    return PW'(int'(row) * DIM + int'(col));
  endfunction

  assign accept      = cmd_val && !busy && (state == IDLE);
  assign a_idx       = flat(ci, ck);
  assign b_idx       = flat(ck, cj);
  assign c_idx       = flat(ci, cj);
  assign last_k      = (ck == LAST_I);
  assign last_mac    = last_k && (cj == LAST_I) && (ci == LAST_I);
  assign unused_bits = ^cmd_config_data;

  tight_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .a     (a_mem[a_idx]),
    .b     (b_mem[b_idx]),
    .acc   (acc),
    .clr   (ck == '0),
    .acc_n (acc_n)
  );

  // Operand/result storage and the running sum carry no reset.
  always_ff @(posedge clk) begin
    if (accept && cmd_opcode == OP_FILLA) a_mem[a_ptr] <= cmd_config_data[DATA_W-1:0];
    if (accept && cmd_opcode == OP_FILLB) b_mem[b_ptr] <= cmd_config_data[DATA_W-1:0];
    if (state == COMPUTE) begin
      acc <= acc_n;
      if (last_k) c_mem[c_idx] <= acc_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      resp_val  <= 1'b0;
      resp_data <= '0;
      resp_err  <= RESP_OK;
      a_ptr     <= '0;
      b_ptr     <= '0;
      rd_ptr    <= '0;
      a_full    <= 1'b0;
      b_full    <= 1'b0;
      c_valid   <= 1'b0;
      ci        <= '0;
      cj        <= '0;
      ck        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            busy      <= 1'b1;
            resp_val  <= 1'b1;
            resp_err  <= RESP_OK;
            resp_data <= '0;
            state     <= RESP;
            case (cmd_opcode)
              OP_FILLA: begin
                resp_data <= 64'(a_ptr);
                c_valid   <= 1'b0;
                if (a_ptr == LAST_P) begin
                  a_ptr  <= '0;
                  a_full <= 1'b1;
                end else begin
                  a_ptr <= a_ptr + 1'b1;
                end
              end
              OP_FILLB: begin
                resp_data <= 64'(b_ptr);
                c_valid   <= 1'b0;
                if (b_ptr == LAST_P) begin
                  b_ptr  <= '0;
                  b_full <= 1'b1;
                end else begin
                  b_ptr <= b_ptr + 1'b1;
                end
              end
              OP_MULT: begin
                if (a_full && b_full) begin
                  resp_val <= 1'b0;
                  state    <= COMPUTE;
                  ci       <= '0;
                  cj       <= '0;
                  ck       <= '0;
                end else begin
                  resp_err <= RESP_ERR;
                end
              end
              OP_READ: begin
                if (c_valid) begin
                  resp_data <= ext64(c_mem[rd_ptr]);
                  rd_ptr    <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
                end else begin
                  resp_err <= RESP_ERR;
                end
              end
              OP_CLEAR: begin
                a_ptr   <= '0;
                b_ptr   <= '0;
                rd_ptr  <= '0;
                a_full  <= 1'b0;
                b_full  <= 1'b0;
                c_valid <= 1'b0;
              end
              default: begin
                resp_err  <= RESP_ERR;
                resp_data <= {58'b0, cmd_opcode};
              end
            endcase
          end
        end
        COMPUTE: begin
          // k innermost, then j, then i; one MAC per cycle.
          if (last_k) begin
            ck <= '0;
            if (cj == LAST_I) begin
              cj <= '0;
              ci <= ci + 1'b1;
            end else begin
              cj <= cj + 1'b1;
            end
          end else begin
            ck <= ck + 1'b1;
          end
          if (last_mac) begin
            state     <= RESP;
            resp_val  <= 1'b1;
            resp_err  <= RESP_OK;
            resp_data <= CYCLES;
            c_valid   <= 1'b1;
            rd_ptr    <= '0;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            resp_val <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tight_matmul_acc.sv
// Directed bench: an unsigned and a signed DIM=2 instance share one command stream;
// expected values are hand-computed matrix products.
module tb_tight_matmul_acc;

  localparam logic [5:0] OP_MULT  = 6'd1;
  localparam logic [5:0] OP_FILLA = 6'd2;
  localparam logic [5:0] OP_FILLB = 6'd3;
  localparam logic [5:0] OP_READ  = 6'd4;
  localparam logic [5:0] OP_CLEAR = 6'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_val;
  logic [5:0]  cmd_opcode;
  logic [63:0] cmd_config_data;
  logic        resp_rdy;

  logic        busy0, resp_val0, rerr0;
  logic [63:0] rdata0;
  logic        busy1, resp_val1, rerr1;
  logic [63:0] rdata1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tight_matmul_acc #(.DIM(2), .DATA_W(32), .ACC_W(64), .SIGNED(0)) u_dut_u (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_val         (cmd_val),
    .busy            (busy0),
    .cmd_opcode      (cmd_opcode),
    .cmd_config_data (cmd_config_data),
    .resp_val        (resp_val0),
    .resp_rdy        (resp_rdy),
    .resp_data       (rdata0),
    .resp_err        (rerr0)
  );

  tight_matmul_acc #(.DIM(2), .DATA_W(32), .ACC_W(64), .SIGNED(1)) u_dut_s (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_val         (cmd_val),
    .busy            (busy1),
    .cmd_opcode      (cmd_opcode),
    .cmd_config_data (cmd_config_data),
    .resp_val        (resp_val1),
    .resp_rdy        (resp_rdy),
    .resp_data       (rdata1),
    .resp_err        (rerr1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [63:0] d);
    int n = 0;
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_tmo", 64'(busy0), 64'd0);
    cmd_opcode      = op;
    cmd_config_data = d;
    cmd_val         = 1'b1;
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    int n = 0;
    while (!resp_val0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("resp_tmo", 64'(resp_val0), 64'd1);
    lat = n;
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic [63:0] d,
                     input logic [63:0] exp0, input logic [63:0] exp1, input logic exp_err);
    int lat;
    send(op, d);
    wait_resp(lat);
    check({tag, "_data"}, rdata0, exp0);
    check({tag, "_err"}, 64'(rerr0), 64'(exp_err));
    check({tag, "_sdata"}, rdata1, exp1);
    check({tag, "_serr"}, 64'(rerr1), 64'(exp_err));
    if (op == OP_MULT && !exp_err) check({tag, "_lat"}, 64'(lat), 64'd8);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] held;
    rst_n           = 1'b0;
    cmd_val         = 1'b0;
    cmd_opcode      = '0;
    cmd_config_data = '0;
    resp_rdy        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_rval", 64'(resp_val0), 64'd0);
    check("rst_rdata", rdata0, 64'd0);
    check("rst_rerr", 64'(rerr0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("read_nomult", OP_READ, 64'd0, 64'd0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++)
      run("filla", OP_FILLA, 64'(i + 1), 64'(i), 64'(i), 1'b0);
    run("mult_halfload", OP_MULT, 64'd0, 64'd0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++)
      run("fillb", OP_FILLB, 64'(i + 5), 64'(i), 64'(i), 1'b0);
    run("mult", OP_MULT, 64'd0, 64'd8, 64'd8, 1'b0);
    run("read_c00", OP_READ, 64'd0, 64'd19, 64'd19, 1'b0);
    run("read_c01", OP_READ, 64'd0, 64'd22, 64'd22, 1'b0);
    run("read_c10", OP_READ, 64'd0, 64'd43, 64'd43, 1'b0);
    run("read_c11", OP_READ, 64'd0, 64'd50, 64'd50, 1'b0);
    run("read_wrap", OP_READ, 64'd0, 64'd19, 64'd19, 1'b0);

    // Stall the response; a command offered meanwhile must be ignored.
    resp_rdy = 1'b0;
    send(OP_READ, 64'd0);
    held = rdata0;
    check("stall_first", held, 64'd22);
    for (int c = 0; c < 5; c++) begin
      cmd_opcode      = OP_FILLA;
      cmd_config_data = 64'd99;
      cmd_val         = 1'b1;
      @(negedge clk);
      check("stall_rval", 64'(resp_val0), 64'd1);
      check("stall_rdata", rdata0, held);
      check("stall_busy", 64'(busy0), 64'd1);
    end
    cmd_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("stall_release", 64'(resp_val0), 64'd0);
    run("read_after_stall", OP_READ, 64'd0, 64'd43, 64'd43, 1'b0);
    run("illegal", 6'h3F, 64'd0, 64'd63, 64'd63, 1'b1);
    run("read_after_ill", OP_READ, 64'd0, 64'd50, 64'd50, 1'b0);

    run("clear", OP_CLEAR, 64'd0, 64'd0, 64'd0, 1'b0);
    run("read_cleared", OP_READ, 64'd0, 64'd0, 64'd0, 1'b1);

    // A = [-3 0; 0 0], B = [4 0; 0 0]
    run("sfilla0", OP_FILLA, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd0, 1'b0);
    for (int i = 1; i < 4; i++)
      run("sfilla", OP_FILLA, 64'd0, 64'(i), 64'(i), 1'b0);
    run("sfillb0", OP_FILLB, 64'd4, 64'd0, 64'd0, 1'b0);
    for (int i = 1; i < 4; i++)
      run("sfillb", OP_FILLB, 64'd0, 64'(i), 64'(i), 1'b0);
    run("smult", OP_MULT, 64'd0, 64'd8, 64'd8, 1'b0);
    run("sread0", OP_READ, 64'd0, 64'h0000_0003_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    run("sread1", OP_READ, 64'd0, 64'd0, 64'd0, 1'b0);

    // Abort a running multiply with an asynchronous reset pulse.
    send(OP_MULT, 64'd0);
    repeat (3) @(negedge clk);
    check("mid_busy", 64'(busy0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy0), 64'd0);
    check("arst_rval", 64'(resp_val0), 64'd0);
    check("arst_sbusy", 64'(busy1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_dropped", 64'(resp_val0), 64'd0);
    run("read_after_rst", OP_READ, 64'd0, 64'd0, 64'd0, 1'b1);
    run("mult_after_rst", OP_MULT, 64'd0, 64'd0, 64'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
